// File: rtl/rvr32_pkg.sv
// Shared core constants: datapath widths, the hard-wired zero register,
// the writeback requester numbering, and a small index-width helper.
package rvr32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // x0 reads as zero, so writes to it are dropped.
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Writeback requester slots on the shared regfile write port.
  localparam int WB_ALU  = 0;
  localparam int WB_LSU  = 1;
  localparam int WB_MDU  = 2;
  localparam int WB_NREQ = 3;

  // Width of an index into n items. A single item still needs one bit of storage.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvr32_rr_arbiter.sv
// Round-robin arbiter. It searches ptr+1, ptr+2, ... and wraps explicitly
// modulo N, so N does not have to be a power of two. The grant is one-hot
// and goes to the first requester found. The caller owns the pointer
// register and updates it on an accepted grant.
module rvr32_rr_arbiter
  import rvr32_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int            cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // Pick the first active request after ptr, in wrap-around order.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (en && !found && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvr32_wb_arbiter.sv
// Writeback arbiter. NREQ producers share the single register-file write
// port. Each cycle one valid producer is granted in round-robin order. The
// winner's rd/data go into a one-entry output stage, which drives the
// regfile during the next cycle. The regfile always accepts, so the stage
// drains every cycle and never pushes back on the producers.
module rvr32_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = rvr32_pkg::XLEN,
  parameter int AW   = rvr32_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 wb_busy
);

  import rvr32_pkg::*;

  localparam int PW = idx_width(NREQ);

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   last;
  logic            xfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Grants stop during a freeze and while reset is asserted. A grant is
  // only ever given to a valid requester, so every grant is a transfer.
  rvr32_rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .en      (~hold & ~rst),
    .ptr     (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign win_rd    = req_rd[int'(gnt_idx)*AW +: AW];
  assign win_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];

  // Round-robin pointer: remember the last winner. After reset it points at
  // the final slot, so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (rst) begin
      last <= PW'(NREQ - 1);
    end else if (xfer) begin
      last <= gnt_idx;
    end
  end

  // Output stage: load the winner, or go idle. Address and data keep their
  // old values when idle. A write to x0 is consumed, but its enable stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_busy  <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      wb_busy <= xfer;
      rf_we   <= xfer && (win_rd != AW'(REG_ZERO));
      if (xfer) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule
